// File: rtl/sonar_scan_controller.sv
// Sonar scan controller: sequences servo settling, one ultrasonic measurement
// and the N_CHARS-character UART report for each servo position, sweeping the
// servo back and forth over positions 0..7 while ligar is held.
module sonar_scan_controller #(
  parameter int unsigned SETTLE_CYCLES  = 32'd10_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 32'd2_500_000,
  parameter int unsigned N_CHARS        = 32'd4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ligar,
  input  logic       fim_medida,
  input  logic       pronto_tx,
  output logic       reset_sensor,
  output logic       medir,
  output logic       partida_tx,
  output logic [1:0] sel_char,
  output logic [2:0] posicao_servo,
  output logic       fim_posicao,
  output logic       erro_medida,
  output logic [3:0] db_estado
);

  localparam int unsigned TIMER_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
  localparam int TW = $clog2(TIMER_MAX + 32'd1);
  typedef logic [TW-1:0] timer_t;

  // Last timer value spent in POSICIONA, giving SETTLE_CYCLES cycles there.
  localparam timer_t SETTLE_LAST = timer_t'(SETTLE_CYCLES - 32'd1);
  // The timer lags the medir pulse by one cycle and erro_medida is registered,
  // so deciding at TIMEOUT_CYCLES-2 makes erro_medida rise exactly
  // TIMEOUT_CYCLES cycles after medir (TIMEOUT_CYCLES must be at least 2).
  localparam timer_t TIMEOUT_LAST = timer_t'(TIMEOUT_CYCLES - 32'd2);
  localparam logic [1:0] LAST_CHAR = 2'(N_CHARS - 32'd1);

  typedef enum logic [3:0] {
    INICIAL        = 4'd0,
    PREPARA        = 4'd1,
    POSICIONA      = 4'd2,
    MEDE           = 4'd3,
    AGUARDA_MEDIDA = 4'd4,
    TRANSMITE      = 4'd5,
    AGUARDA_TX     = 4'd6,
    PROXIMO        = 4'd7,
    FIM_POSICAO    = 4'd8
  } state_t;

  state_t     state_r, state_s;
  timer_t     timer_r, timer_s;
  logic [1:0] sel_r, sel_s;
  logic [2:0] pos_r, pos_s;
  logic       dir_up_r, dir_up_s;
  logic       erro_r, erro_s;
  logic       reset_sensor_r, medir_r, partida_tx_r, fim_posicao_r;

  // State and datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r  <= INICIAL;
      timer_r  <= '0;
      sel_r    <= 2'd0;
      pos_r    <= 3'd0;
      dir_up_r <= 1'b1;
      erro_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      timer_r  <= timer_s;
      sel_r    <= sel_s;
      pos_r    <= pos_s;
      dir_up_r <= dir_up_s;
      erro_r   <= erro_s;
    end
  end

  // Next-state, timer, character index, sweep position and error flag.
  always_comb begin
    state_s  = state_r;
    timer_s  = timer_r;
    sel_s    = sel_r;
    pos_s    = pos_r;
    dir_up_s = dir_up_r;
    erro_s   = erro_r;
    case (state_r)
      INICIAL: begin
        if (ligar) begin
          state_s = PREPARA;
        end else begin
          state_s = INICIAL;
        end
      end
      PREPARA: begin
        timer_s = '0;
        state_s = POSICIONA;
      end
      POSICIONA: begin
        if (timer_r == SETTLE_LAST) begin
          timer_s = '0;
          erro_s  = 1'b0;  // drops together with the medir pulse
          state_s = MEDE;
        end else begin
          timer_s = timer_r + timer_t'(1'b1);
        end
      end
      MEDE: begin
        timer_s = '0;
        state_s = AGUARDA_MEDIDA;
      end
      AGUARDA_MEDIDA: begin
        // A measurement arriving on the timeout cycle takes priority.
        if (fim_medida) begin
          state_s = TRANSMITE;
        end else if (timer_r == TIMEOUT_LAST) begin
          erro_s  = 1'b1;
          state_s = TRANSMITE;
        end else begin
          timer_s = timer_r + timer_t'(1'b1);
        end
      end
      TRANSMITE: begin
        state_s = AGUARDA_TX;
      end
      AGUARDA_TX: begin
        if (pronto_tx) begin
          state_s = PROXIMO;
        end else begin
          state_s = AGUARDA_TX;
        end
      end
      PROXIMO: begin
        if (sel_r < LAST_CHAR) begin
          sel_s   = sel_r + 2'd1;
          state_s = TRANSMITE;
        end else begin
          sel_s   = 2'd0;
          state_s = FIM_POSICAO;
        end
      end
      FIM_POSICAO: begin
        // Ping-pong sweep: 0..7 upwards, then 6..0 downwards, and again.
        if (dir_up_r) begin
          if (pos_r == 3'd7) begin
            pos_s    = 3'd6;
            dir_up_s = 1'b0;
          end else begin
            pos_s = pos_r + 3'd1;
          end
        end else begin
          if (pos_r == 3'd0) begin
            pos_s    = 3'd1;
            dir_up_s = 1'b1;
          end else begin
            pos_s = pos_r - 3'd1;
          end
        end
        if (ligar) begin
          timer_s = '0;
          state_s = POSICIONA;
        end else begin
          state_s = INICIAL;
        end
      end
      default: begin
        state_s = INICIAL;
      end
    endcase
  end

  // Pulse outputs registered from the next state so they align with it.
  always_ff @(posedge clock) begin
    if (reset) begin
      reset_sensor_r <= 1'b0;
      medir_r        <= 1'b0;
      partida_tx_r   <= 1'b0;
      fim_posicao_r  <= 1'b0;
    end else begin
      reset_sensor_r <= (state_s == PREPARA);
      medir_r        <= (state_s == MEDE);
      partida_tx_r   <= (state_s == TRANSMITE);
      fim_posicao_r  <= (state_s == FIM_POSICAO);
    end
  end

  assign reset_sensor  = reset_sensor_r;
  assign medir         = medir_r;
  assign partida_tx    = partida_tx_r;
  assign fim_posicao   = fim_posicao_r;
  assign sel_char      = sel_r;
  assign posicao_servo = pos_r;
  assign erro_medida   = erro_r;
  assign db_estado     = state_r;

endmodule

// File: tb/tb_sonar_scan_controller.sv
// Self-checking bench for sonar_scan_controller with a short settle time and
// timeout; expected UART characters and end-of-position pulses are queued as
// each position is driven and compared by a monitor when the DUT pulses.
module tb_sonar_scan_controller;

  logic       clock;
  logic       reset;
  logic       ligar;
  logic       fim_medida;
  logic       pronto_tx;
  logic       reset_sensor;
  logic       medir;
  logic       partida_tx;
  logic [1:0] sel_char;
  logic [2:0] posicao_servo;
  logic       fim_posicao;
  logic       erro_medida;
  logic [3:0] db_estado;

  sonar_scan_controller #(
    .SETTLE_CYCLES (32'd4),
    .TIMEOUT_CYCLES(32'd100),
    .N_CHARS       (32'd4)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .ligar        (ligar),
    .fim_medida   (fim_medida),
    .pronto_tx    (pronto_tx),
    .reset_sensor (reset_sensor),
    .medir        (medir),
    .partida_tx   (partida_tx),
    .sel_char     (sel_char),
    .posicao_servo(posicao_servo),
    .fim_posicao  (fim_posicao),
    .erro_medida  (erro_medida),
    .db_estado    (db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int tx_count = 0;
  int fim_count = 0;

  logic [5:0] tx_q [$];   // {posicao, sel_char, erro}
  logic [2:0] fin_q [$];  // posicao during fim_posicao

  logic [2:0] model_pos = 3'd0;
  logic       model_up = 1'b1;

  logic [3:0] walk_db [6] = '{4'd1, 4'd2, 4'd2, 4'd2, 4'd2, 4'd3};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic sig(input int which);
    case (which)
      0: sig = medir;
      1: sig = partida_tx;
      default: sig = fim_posicao;
    endcase
  endfunction

  // Wait until the selected pulse is visible, checking the current cycle first.
  task automatic wait_for(input int which, input int budget, input string tag);
    for (int n = 0; n < budget; n++) begin
      if (sig(which)) return;
      step();
    end
    check_eq(tag, 32'd0, 32'd1);
  endtask

  task automatic advance_model();
    if (model_up) begin
      if (model_pos == 3'd7) begin
        model_pos = 3'd6;
        model_up = 1'b0;
      end else begin
        model_pos = model_pos + 3'd1;
      end
    end else begin
      if (model_pos == 3'd0) begin
        model_pos = 3'd1;
        model_up = 1'b1;
      end else begin
        model_pos = model_pos - 3'd1;
      end
    end
  endtask

  // Serve one position starting in the medir cycle. med_delay<0 means no
  // measurement answer; drop_at is the char during whose wait ligar drops.
  task automatic respond(input int med_delay, input int tx_delay, input int drop_at);
    logic exp_err;
    exp_err = (med_delay < 0);
    for (int i = 0; i < 4; i++) tx_q.push_back({model_pos, 2'(i), exp_err});
    fin_q.push_back(model_pos);
    advance_model();
    if (med_delay < 0) begin
      for (int k = 1; k <= 100; k++) begin
        step();
        if (k == 99) check_eq("erro_before_timeout", 32'(erro_medida), 32'd0);
        if (k == 100) check_eq("erro_at_timeout", 32'(erro_medida), 32'd1);
      end
    end else begin
      repeat (med_delay) step();
      fim_medida = 1'b1;
      step();
      fim_medida = 1'b0;
      check_eq("partida_latency", 32'(partida_tx), 32'd1);
    end
    for (int c = 0; c < 4; c++) begin
      wait_for(1, 50, "partida_wait");
      if (c == drop_at) ligar = 1'b0;
      repeat (tx_delay) step();
      pronto_tx = 1'b1;
      step();
      pronto_tx = 1'b0;
    end
    wait_for(2, 20, "fim_posicao_wait");
    step();
    check_eq("pos_after_fim", 32'(posicao_servo), 32'(model_pos));
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clock) begin
    logic [5:0] rec;
    logic [2:0] fp;
    if (partida_tx) begin
      tx_count++;
      if (tx_q.size() == 0) begin
        check_eq("tx_extra", 32'd1, 32'd0);
      end else begin
        rec = tx_q.pop_front();
        check_eq("tx_pos", 32'(posicao_servo), 32'(rec[5:3]));
        check_eq("tx_sel", 32'(sel_char), 32'(rec[2:1]));
        check_eq("tx_err", 32'(erro_medida), 32'(rec[0]));
      end
    end
    if (fim_posicao) begin
      fim_count++;
      if (fin_q.size() == 0) begin
        check_eq("fim_extra", 32'd1, 32'd0);
      end else begin
        fp = fin_q.pop_front();
        check_eq("fim_pos", 32'(posicao_servo), 32'(fp));
      end
    end
    if (medir) check_eq("medir_erro_clear", 32'(erro_medida), 32'd0);
  end

  initial begin
    int t0;
    int f0;
    reset = 1'b1;
    ligar = 1'b0;
    fim_medida = 1'b0;
    pronto_tx = 1'b0;
    repeat (2) step();
    check_eq("rst_outputs", 32'({reset_sensor, medir, partida_tx, sel_char, posicao_servo,
                                 fim_posicao, erro_medida}), 32'd0);
    check_eq("rst_state", 32'(db_estado), 32'd0);
    reset = 1'b0;
    step();
    check_eq("idle_state", 32'(db_estado), 32'd0);

    // Start-up walk: PREPARA, four POSICIONA cycles, MEDE.
    ligar = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check_eq("walk_db", 32'(db_estado), 32'(walk_db[i]));
      check_eq("walk_reset_sensor", 32'(reset_sensor), (i == 0) ? 32'd1 : 32'd0);
      check_eq("walk_medir", 32'(medir), (i == 5) ? 32'd1 : 32'd0);
    end
    check_eq("first_pos", 32'(posicao_servo), 32'd0);
    t0 = tx_count;
    respond(20, 10, -1);
    check_eq("first_tx_count", 32'(tx_count - t0), 32'd4);
    check_eq("first_no_err", 32'(erro_medida), 32'd0);

    // Sixteen positions with ligar held: ping-pong sweep.
    f0 = fim_count;
    for (int p = 0; p < 16; p++) begin
      wait_for(0, 30, "sweep_medir_wait");
      respond(1, 1, -1);
    end
    check_eq("sweep_fim_count", 32'(fim_count - f0), 32'd16);

    // Measurement timeout.
    wait_for(0, 30, "timeout_medir_wait");
    respond(-1, 2, -1);
    check_eq("erro_held", 32'(erro_medida), 32'd1);

    // ligar dropped while char 1 is in flight; resume later.
    wait_for(0, 30, "drop_medir_wait");
    respond(5, 3, 1);
    check_eq("drop_idle", 32'(db_estado), 32'd0);
    repeat (5) step();
    check_eq("drop_still_idle", 32'(db_estado), 32'd0);
    ligar = 1'b1;
    wait_for(0, 30, "resume_medir_wait");
    respond(2, 2, -1);

    // Reset while waiting for the measurement, with fim_medida coincident.
    wait_for(0, 30, "abort_medir_wait");
    repeat (3) step();
    t0 = tx_count;
    reset = 1'b1;
    fim_medida = 1'b1;
    ligar = 1'b0;
    step();
    reset = 1'b0;
    fim_medida = 1'b0;
    check_eq("abort_outputs", 32'({reset_sensor, medir, partida_tx, sel_char, fim_posicao,
                                   erro_medida}), 32'd0);
    check_eq("abort_state", 32'(db_estado), 32'd0);
    check_eq("abort_pos", 32'(posicao_servo), 32'd0);
    repeat (20) step();
    check_eq("abort_no_tx", 32'(tx_count - t0), 32'd0);
    check_eq("abort_idle", 32'(db_estado), 32'd0);

    check_eq("tx_q_drained", 32'(tx_q.size()), 32'd0);
    check_eq("fin_q_drained", 32'(fin_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sonar_scan_controller.md
Name: sonar_scan_controller

Overview:
Control FSM for the sonar subsystem. Sequences the servo sweep, the ultrasonic measurement and the UART transmission of each reading. Drives the start, reset and select inputs of the sensor interface, servo controller and UART datapath. Sits between the top-level `ligar` switch and those three units, and replaces ad-hoc sequencing in the sonar top.

Parameters:
SETTLE_CYCLES, 10_000_000, clock cycles the servo is given to settle after a position change (200 ms at 50 MHz)
TIMEOUT_CYCLES, 2_500_000, maximum cycles to wait for fim_medida after medir (50 ms)
N_CHARS, 4, characters sent per position (3 distance digits + '#')

Ports:
clock  in  1  system clock, 50 MHz
reset  in  1  synchronous, active-high
ligar  in  1  enable sweep (level)
fim_medida  in  1  1-cycle pulse from sensor interface: measurement done
pronto_tx  in  1  1-cycle pulse from UART: character sent
reset_sensor  out  1  1-cycle clear of sensor interface and UART
medir  out  1  1-cycle measurement start
partida_tx  out  1  1-cycle UART start
sel_char  out  2  index of the character the datapath muxes into the UART (0..N_CHARS-1)
posicao_servo  out  3  servo position 0..7
fim_posicao  out  1  1-cycle pulse: position fully processed
erro_medida  out  1  timeout flag for the current position; datapath sends "???" while set
db_estado  out  4  state encoding, for debug display

Behaviour:
- Reset (synchronous, active-high; all clock edges are rising):
  - all outputs 0; state INICIAL; direction up.
  - Timer and sel_char cleared.
  - Reset mid-operation aborts immediately with no further pulses.
- State encoding for db_estado: INICIAL=0, PREPARA=1, POSICIONA=2, MEDE=3, AGUARDA_MEDIDA=4, TRANSMITE=5, AGUARDA_TX=6, PROXIMO=7, FIM_POSICAO=8. Unused codes go to INICIAL.
- INICIAL: idle. ligar=1 sampled -> PREPARA on the next edge.
- PREPARA: reset_sensor=1 for exactly 1 cycle; timer cleared -> POSICIONA.
- POSICIONA: posicao_servo is stable; the timer counts. After SETTLE_CYCLES cycles in this state -> MEDE.
- MEDE: medir=1 for 1 cycle; erro_medida cleared; timer cleared -> AGUARDA_MEDIDA.
- AGUARDA_MEDIDA:
  - fim_medida=1 -> TRANSMITE.
  - Timer reaching TIMEOUT_CYCLES without fim_medida -> erro_medida=1, then TRANSMITE.
  - If fim_medida arrives on the same cycle as the timeout, fim_medida wins and erro_medida stays 0.
- TRANSMITE: partida_tx=1 for 1 cycle -> AGUARDA_TX. sel_char holds its value.
- AGUARDA_TX: waits without limit for pronto_tx. pronto_tx -> PROXIMO.
- PROXIMO:
  - sel_char < N_CHARS-1: increment sel_char, then TRANSMITE.
  - Otherwise: sel_char=0, then FIM_POSICAO.
- FIM_POSICAO:
  - fim_posicao=1 for 1 cycle.
  - Position is updated on exit as a ping-pong sweep: up from 0 to 7, then down from 7 to 0. At 7 with direction up, go to 6 and set direction down. At 0 with direction down, go to 1 and set direction up. The sequence is 0,1,…,7,6,…,0,1,…
  - Exit: ligar=1 -> POSICIONA with timer cleared. ligar=0 -> INICIAL; position and direction are retained.
- ligar dropped mid-position: ignored until FIM_POSICAO. The current position always completes its N_CHARS characters.
- Pulses arriving outside their waiting state are ignored and not latched: fim_medida outside AGUARDA_MEDIDA, pronto_tx outside AGUARDA_TX.
- erro_medida holds from the timeout until the next MEDE.
- Timer width is sized for max(SETTLE_CYCLES, TIMEOUT_CYCLES); it must not wrap before the terminal count.
- Minimum latency with SETTLE_CYCLES=S, immediate fim_medida and pronto_tx:
  - ligar to medir = 2+S cycles.
  - First partida_tx follows one cycle after the cycle in which fim_medida is seen.

Test Plan (SETTLE_CYCLES=4, TIMEOUT_CYCLES=100, N_CHARS=4):
1. Reset 2 cycles, then ligar=1 -> reset_sensor pulses 1 cycle later; medir pulses 4 cycles after leaving PREPARA; posicao_servo=0; db_estado walks 0→1→2→3→4.
2. fim_medida 20 cycles after medir, then pronto_tx 10 cycles after each partida_tx -> exactly 4 partida_tx pulses with sel_char=0,1,2,3; then fim_posicao 1 cycle; posicao_servo becomes 1; erro_medida stays 0.
3. ligar held, auto-respond to all pulses for 16 positions -> posicao_servo sequence 0,1,…,7,6,…,0,1; 16 fim_posicao pulses.
4. No fim_medida -> erro_medida=1 exactly 100 cycles after medir; 4 characters still sent; erro_medida clears at the next medir.
5. ligar=0 during AGUARDA_TX of char 1 -> chars 2 and 3 still sent; fim_posicao pulses; state returns to 0. ligar=1 again -> next position resumes from the retained value.
6. reset=1 for 1 cycle in AGUARDA_MEDIDA, with fim_medida pulsed at the same time -> all outputs 0, db_estado=0, posicao_servo=0, no partida_tx.
